// File: rtl/axa_pkg.sv
// axa_pkg: AXA opcodes, instruction field positions, bubble word and fetch-state encoding
package axa_pkg;
  localparam int IOPLEN = 6;
  localparam int IL_OP_MSB = 15;
  localparam int IL_OP_LSB = 10;
  localparam int IS_OP_MSB = 15;
  localparam int IS_OP_LSB = 12;
  localparam logic [5:0] OPxhi = 6'b100000;
  localparam logic [5:0] OPllo = 6'b100001;
  localparam logic [5:0] OPbz = 6'b101000;
  localparam logic [5:0] OPbnz = 6'b101001;
  localparam logic [5:0] OPfail = 6'b110001;
  localparam logic [5:0] OPsys = 6'b111000;
  localparam logic [5:0] OPnop = 6'b111010;
  localparam logic [15:0] NOP_INST = {OPnop, 10'b0};
  typedef enum logic [1:0] {RUN = 2'd0, BR_WAIT = 2'd1, HALTED = 2'd2} fetch_state_t;
endpackage

// File: rtl/axa_fetch_stage_if.sv
// axa_fetch_stage_if: instruction-memory port, redirect inputs and the downstream valid/ready stream
//   master = fetch stage, slave = memory + consumer + branch resolver
interface axa_fetch_stage_if #(parameter int WORD_W = 16, parameter int IM_AW = 16);
  logic [IM_AW-1:0] im_addr;
  logic [WORD_W-1:0] im_data;
  logic redirect_valid;
  logic [WORD_W-1:0] redirect_pc;
  logic [WORD_W-1:0] redirect_from;
  logic branch_nt;
  logic out_valid;
  logic out_ready;
  logic [WORD_W-1:0] out_ir;
  logic [WORD_W-1:0] out_lastpc;
  modport master(output im_addr, out_valid, out_ir, out_lastpc,
                 input im_data, redirect_valid, redirect_pc, redirect_from, branch_nt, out_ready);
  modport slave(input im_addr, out_valid, out_ir, out_lastpc,
                output im_data, redirect_valid, redirect_pc, redirect_from, branch_nt, out_ready);
endinterface

// File: rtl/axa_skid_fifo.sv
// axa_skid_fifo: small circular FIFO with push/pop/flush; head is the oldest entry, no bypass
//   clk, reset (async active-low), push, pop, flush, din -> head, count, full
module axa_skid_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  assign head = mem[rd];
  assign full = count == (AW+1)'(DEPTH);
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + AW'(1);
      if (pop) rd <= rd + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/axa_fetch_stage.sv
// axa_fetch_stage: PC owner, instruction fetch with branch/stop pre-decode, skid FIFO to decode
//   clk, reset (async active-low), bus (master: im port, redirect, out stream), fetch_state (debug)
module axa_fetch_stage
  import axa_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int IM_AW = 16,
  parameter int FIFO_D = 2
) (
  input  logic                clk,
  input  logic                reset,
  axa_fetch_stage_if.master   bus,
  output logic [1:0]          fetch_state
);
  localparam int CW = $clog2(FIFO_D) + 1;
  fetch_state_t state;
  logic [WORD_W-1:0] pc, lastpc_r;
  logic [2*WORD_W-1:0] head;
  logic [CW-1:0] count;
  logic full, valid, redir, fire, pop, is_branch, is_stop;
  logic [IOPLEN-1:0] op;
  assign op = bus.im_data[IL_OP_MSB:IL_OP_LSB];
  // Short forms have bit15=0, so these long-form patterns can never match them.
  assign is_branch = op[5:3] == 3'b101;
  assign is_stop = op == OPsys || op == OPfail;
  assign redir = bus.redirect_valid && state != HALTED;
  assign fire = state == RUN && (!full || bus.out_ready) && !redir;
  assign valid = count != '0;
  assign pop = bus.out_ready && valid;
  assign bus.im_addr = pc[IM_AW-1:0];
  assign bus.out_valid = valid;
  assign bus.out_ir = valid ? head[2*WORD_W-1:WORD_W] : NOP_INST;
  assign bus.out_lastpc = valid ? head[WORD_W-1:0] : '0;
  assign fetch_state = state;
  axa_skid_fifo #(.WIDTH(2*WORD_W), .DEPTH(FIFO_D)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(fire),
    .pop(pop),
    .flush(redir),
    .din({bus.im_data, lastpc_r}),
    .head(head),
    .count(count),
    .full(full)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc <= '0;
      lastpc_r <= '0;
      state <= RUN;
    end else if (redir) begin
      pc <= bus.redirect_pc;
      lastpc_r <= bus.redirect_from;
      state <= RUN;
    end else if (fire) begin
      lastpc_r <= pc;
      pc <= pc + WORD_W'(1);
      state <= is_branch ? BR_WAIT : is_stop ? HALTED : RUN;
    end else if (state == BR_WAIT && bus.branch_nt) begin
      state <= RUN;
    end
endmodule

// File: tb/tb_axa_fetch_stage.sv
// tb_axa_fetch_stage: directed scenarios against hand-computed fetch stream values
module tb_axa_fetch_stage;
  import axa_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] fetch_state;
  int checks = 0;
  int failures = 0;
  logic [15:0] im [0:65535];
  axa_fetch_stage_if bus();
  assign bus.im_data = im[bus.im_addr];
  axa_fetch_stage dut (.clk(clk), .reset(reset), .bus(bus), .fetch_state(fetch_state));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.redirect_from = '0;
    bus.branch_nt = 1'b0;
    for (int i = 0; i < 65536; i++) im[i] = NOP_INST;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0h want 0", bus.out_valid); end
    checks++; if (bus.out_ir !== 16'hE800) begin failures++; $display("FAIL reset_ir: got %h want e800", bus.out_ir); end
    checks++; if (bus.out_lastpc !== 16'h0000) begin failures++; $display("FAIL reset_lastpc: got %h want 0000", bus.out_lastpc); end
    checks++; if (fetch_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", fetch_state); end
    checks++; if (bus.im_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr: got %h want 0000", bus.im_addr); end
  endtask
  task automatic test_straight_line;
    logic [15:0] ir [4] = '{16'h8405, 16'h1123, 16'h3456, 16'hE000};
    logic [15:0] lp [4] = '{16'h0000, 16'h0000, 16'h0001, 16'h0002};
    do_reset();
    for (int i = 0; i < 4; i++) im[i] = ir[i];
    bus.out_ready = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_ir !== ir[i]) begin failures++; $display("FAIL straight_ir[%0d]: got v=%0h ir=%h want v=1 ir=%h", i, bus.out_valid, bus.out_ir, ir[i]); end
      checks++; if (bus.out_lastpc !== lp[i]) begin failures++; $display("FAIL straight_lastpc[%0d]: got %h want %h", i, bus.out_lastpc, lp[i]); end
    end
    checks++; if (fetch_state !== 2'd2) begin failures++; $display("FAIL straight_halted: got %0d want 2", fetch_state); end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_ir !== 16'hE800) begin failures++; $display("FAIL straight_nofetch: got v=%0h ir=%h want v=0 ir=e800", bus.out_valid, bus.out_ir); end
    checks++; if (bus.im_addr !== 16'h0004) begin failures++; $display("FAIL straight_pc: got %h want 0004", bus.im_addr); end
  endtask
  task automatic test_backpressure;
    logic [15:0] ir [3] = '{16'h2222, 16'h3333, 16'h4444};
    logic [15:0] lp [3] = '{16'h0000, 16'h0001, 16'h0002};
    do_reset();
    im[0] = 16'h1111; im[1] = 16'h2222; im[2] = 16'h3333; im[3] = 16'h4444;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (bus.im_addr !== 16'h0002) begin failures++; $display("FAIL bp_addr_held: got %h want 0002", bus.im_addr); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ir !== 16'h1111 || bus.out_lastpc !== 16'h0000) begin failures++; $display("FAIL bp_head: got v=%0h ir=%h lp=%h want v=1 ir=1111 lp=0000", bus.out_valid, bus.out_ir, bus.out_lastpc); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.out_ir !== ir[i] || bus.out_lastpc !== lp[i]) begin failures++; $display("FAIL bp_drain[%0d]: got ir=%h lp=%h want ir=%h lp=%h", i, bus.out_ir, bus.out_lastpc, ir[i], lp[i]); end
    end
  endtask
  task automatic test_taken_branch;
    do_reset();
    for (int i = 0; i < 5; i++) im[i] = 16'h1000 + 16'(i);
    im[5] = 16'hA000; im[6] = 16'h1006; im[32] = 16'h2020;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (fetch_state !== 2'd1 || bus.out_ir !== 16'hA000 || bus.im_addr !== 16'h0006) begin failures++; $display("FAIL br_wait: got st=%0d ir=%h addr=%h want st=1 ir=a000 addr=0006", fetch_state, bus.out_ir, bus.im_addr); end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.im_addr !== 16'h0006) begin failures++; $display("FAIL br_nopush: got v=%0h addr=%h want v=0 addr=0006", bus.out_valid, bus.im_addr); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0020; bus.redirect_from = 16'h0005;
    tick();
    bus.redirect_valid = 1'b0;
    checks++; if (fetch_state !== 2'd0 || bus.im_addr !== 16'h0020 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL br_redirect: got st=%0d addr=%h v=%0h want st=0 addr=0020 v=0", fetch_state, bus.im_addr, bus.out_valid); end
    tick();
    checks++; if (bus.out_ir !== 16'h2020 || bus.out_lastpc !== 16'h0005) begin failures++; $display("FAIL br_target: got ir=%h lp=%h want ir=2020 lp=0005", bus.out_ir, bus.out_lastpc); end
  endtask
  task automatic test_not_taken;
    do_reset();
    for (int i = 0; i < 7; i++) im[i] = 16'h1000 + 16'(i);
    im[7] = 16'hA400; im[8] = 16'h1808;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (fetch_state !== 2'd1 || bus.out_ir !== 16'hA400 || bus.out_lastpc !== 16'h0006) begin failures++; $display("FAIL nt_branch: got st=%0d ir=%h lp=%h want st=1 ir=a400 lp=0006", fetch_state, bus.out_ir, bus.out_lastpc); end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || fetch_state !== 2'd1) begin failures++; $display("FAIL nt_wait: got v=%0h st=%0d want v=0 st=1", bus.out_valid, fetch_state); end
    bus.branch_nt = 1'b1;
    tick();
    bus.branch_nt = 1'b0;
    checks++; if (fetch_state !== 2'd0 || bus.im_addr !== 16'h0008) begin failures++; $display("FAIL nt_resume: got st=%0d addr=%h want st=0 addr=0008", fetch_state, bus.im_addr); end
    tick();
    checks++; if (bus.out_ir !== 16'h1808 || bus.out_lastpc !== 16'h0007) begin failures++; $display("FAIL nt_next: got ir=%h lp=%h want ir=1808 lp=0007", bus.out_ir, bus.out_lastpc); end
  endtask
  task automatic test_wrap_priority;
    do_reset();
    im[16'hFFFF] = 16'h1FFF; im[0] = 16'hA000; im[16'h0040] = 16'hC400;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'hFFFF; bus.redirect_from = 16'h1234;
    reset = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.im_addr !== 16'hFFFF || bus.out_valid !== 1'b0) begin failures++; $display("FAIL wrap_redirect: got addr=%h v=%0h want addr=ffff v=0", bus.im_addr, bus.out_valid); end
    tick();
    checks++; if (bus.out_ir !== 16'h1FFF || bus.out_lastpc !== 16'h1234 || bus.im_addr !== 16'h0000) begin failures++; $display("FAIL wrap_pc: got ir=%h lp=%h addr=%h want ir=1fff lp=1234 addr=0000", bus.out_ir, bus.out_lastpc, bus.im_addr); end
    tick();
    checks++; if (bus.out_lastpc !== 16'hFFFF || fetch_state !== 2'd1) begin failures++; $display("FAIL wrap_lastpc: got lp=%h st=%0d want lp=ffff st=1", bus.out_lastpc, fetch_state); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0040; bus.redirect_from = 16'h0000; bus.branch_nt = 1'b1;
    tick();
    bus.redirect_valid = 1'b0; bus.branch_nt = 1'b0;
    checks++; if (bus.im_addr !== 16'h0040 || fetch_state !== 2'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL prio_redirect: got addr=%h st=%0d v=%0h want addr=0040 st=0 v=0", bus.im_addr, fetch_state, bus.out_valid); end
    tick();
    checks++; if (bus.out_ir !== 16'hC400 || bus.out_lastpc !== 16'h0000 || fetch_state !== 2'd2) begin failures++; $display("FAIL prio_fail: got ir=%h lp=%h st=%0d want ir=c400 lp=0000 st=2", bus.out_ir, bus.out_lastpc, fetch_state); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0080; bus.branch_nt = 1'b1;
    tick();
    bus.redirect_valid = 1'b0; bus.branch_nt = 1'b0;
    checks++; if (fetch_state !== 2'd2 || bus.im_addr !== 16'h0041 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL halted_ignore: got st=%0d addr=%h v=%0h want st=2 addr=0041 v=0", fetch_state, bus.im_addr, bus.out_valid); end
  endtask
  task automatic test_async_reset;
    do_reset();
    im[0] = 16'h7770; im[1] = 16'h7771; im[2] = 16'h7772;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.im_addr !== 16'h0002) begin failures++; $display("FAIL ar_full: got v=%0h addr=%h want v=1 addr=0002", bus.out_valid, bus.im_addr); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_ir !== 16'hE800 || bus.out_lastpc !== 16'h0000) begin failures++; $display("FAIL ar_outputs: got v=%0h ir=%h lp=%h want v=0 ir=e800 lp=0000", bus.out_valid, bus.out_ir, bus.out_lastpc); end
    checks++; if (bus.im_addr !== 16'h0000 || fetch_state !== 2'd0) begin failures++; $display("FAIL ar_pc: got addr=%h st=%0d want addr=0000 st=0", bus.im_addr, fetch_state); end
    #1 reset = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_ir !== 16'h7770 || bus.out_lastpc !== 16'h0000 || bus.im_addr !== 16'h0001) begin failures++; $display("FAIL ar_refetch: got ir=%h lp=%h addr=%h want ir=7770 lp=0000 addr=0001", bus.out_ir, bus.out_lastpc, bus.im_addr); end
  endtask
  initial begin
    test_reset();
    test_straight_line();
    test_backpressure();
    test_taken_branch();
    test_not_taken();
    test_wrap_priority();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
